// File: rtl/block_lock_ctrl_if.sv
// Block-lock lane bus: header stream in, slip/lock/descrambler-enable/status out.
// master = header source and status consumer, slave = the lock controller.
interface block_lock_ctrl_if #(
    parameter int ERR_W = 16
);
    logic             hdr_valid;
    logic [1:0]       sync_hdr;
    logic             cnt_clr;
    logic             slip;
    logic             block_lock;
    logic             descr_en;
    logic             hdr_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output hdr_valid, sync_hdr, cnt_clr,
        input  slip, block_lock, descr_en, hdr_err, err_cnt
    );

    modport slave (
        input  hdr_valid, sync_hdr, cnt_clr,
        output slip, block_lock, descr_en, hdr_err, err_cnt
    );
endinterface

// File: rtl/block_lock_ctrl.sv
// 66b sync-header block-lock controller for one PCS lane: hunts via gearbox slips,
// declares/drops lock, and gates the descrambler on locked blocks.
module block_lock_ctrl #(
    parameter int LOCK_CNT  = 64,
    parameter int ERR_LIMIT = 16,
    parameter int SLIP_WAIT = 4,
    parameter int ERR_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    block_lock_ctrl_if.slave   bus
);
    localparam int SH_W = $clog2(LOCK_CNT + 1);
    localparam int IV_W = $clog2(ERR_LIMIT + 1);
    localparam int WT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

    typedef enum logic [1:0] {HUNT, SLIP_WT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [IV_W-1:0]  invld_cnt_q, invld_cnt_d;
    logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             slip_q, slip_d;
    logic             block_lock_q, block_lock_d;
    logic             hdr_err_q, hdr_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             hdr_ok;
    logic [SH_W-1:0]  sh_inc;
    logic [IV_W-1:0]  iv_inc;

    // 01/10 are the only legal sync headers
    assign hdr_ok = bus.sync_hdr[1] ^ bus.sync_hdr[0];
    assign sh_inc = sh_cnt_q + SH_W'(1);
    assign iv_inc = invld_cnt_q + IV_W'(1);

    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        invld_cnt_d  = invld_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        slip_d       = 1'b0;
        block_lock_d = block_lock_q;
        hdr_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            HUNT: begin
                if (bus.hdr_valid) begin
                    if (!hdr_ok) begin
                        slip_d      = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        wait_cnt_d  = '0;
                        state_d     = SLIP_WT;
                    end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                        block_lock_d = 1'b1;
                        sh_cnt_d     = '0;
                        invld_cnt_d  = '0;
                        state_d      = LOCKED;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
            end
            SLIP_WT: begin
                // gearbox output is unsettled here, so headers are not looked at
                wait_cnt_d = wait_cnt_q + WT_W'(1);
                if (wait_cnt_q == WT_W'(SLIP_WAIT - 1)) state_d = HUNT;
            end
            LOCKED: begin
                if (bus.hdr_valid) begin
                    sh_cnt_d = sh_inc;
                    if (!hdr_ok) begin
                        invld_cnt_d = iv_inc;
                        hdr_err_d   = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    // lock loss takes priority over closing the window
                    if (!hdr_ok && iv_inc == IV_W'(ERR_LIMIT)) begin
                        block_lock_d = 1'b0;
                        slip_d       = 1'b1;
                        sh_cnt_d     = '0;
                        invld_cnt_d  = '0;
                        wait_cnt_d   = '0;
                        state_d      = SLIP_WT;
                    end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (bus.cnt_clr) err_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HUNT;
            sh_cnt_q     <= '0;
            invld_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            slip_q       <= 1'b0;
            block_lock_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            invld_cnt_q  <= invld_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            slip_q       <= slip_d;
            block_lock_q <= block_lock_d;
            hdr_err_q    <= hdr_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.slip       = slip_q;
    assign bus.block_lock = block_lock_q;
    assign bus.hdr_err    = hdr_err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.descr_en   = bus.hdr_valid & block_lock_q;
endmodule
